// File: rtl/text_dot_generator_if.sv
// Host write port into the character RAM.
// Valid/ready handshake; a write happens when both are high.
interface text_dot_generator_if;
  logic       wr_valid;
  logic [9:0] wr_addr;
  logic [6:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/text_dot_generator.sv
// 32x30 text overlay: character RAM, font fetch FSM and dot shifter.
// Dots trail the video counters by one clock.
module text_dot_generator (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] clock_counter,
  input  logic [8:0]  line_counter,
  text_dot_generator_if.slave wr,
  input  logic [9:0]  cursor_addr,
  input  logic        cursor_en,
  output logic [9:0]  font_addr,
  input  logic [5:0]  font_data,
  output logic        dot
);

  typedef enum logic [1:0] {
    IDLE,
    CHAR,
    FONT,
    LATCH
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] phase_q, phase_d, phase_c;
  logic [5:0] col_q, col_d, col_c;
  logic       sync_q, sync_c;
  logic [5:0] shift_q, shift_d;
  logic [5:0] pend_q, pend_d;
  logic [9:0] idx_q, idx_d;
  logic [9:0] font_addr_q;
  logic [6:0] code_q;
  logic [4:0] frame_q, frame_d;
  logic       blink_q, blink_d;
  logic       dot_q, dot_d;
  logic [6:0] mem [1024];

  logic       cell_start;
  logic       line_act;
  logic       pix_act;
  logic       frame_tick;
  logic       ready_c;
  logic       wr_en;
  logic       inv;
  logic       load;
  logic [8:0] line_off;
  logic [9:0] row_w;
  logic [9:0] rd_idx;

  // The counters read as zero in the 336 cycle itself, so the
  // shifter lines up with clock 384 without a registered delay.
  assign cell_start = clock_counter == 11'd336;
  assign phase_c    = cell_start ? 6'd0 : phase_q;
  assign col_c      = cell_start ? 6'd0 : col_q;
  assign sync_c     = sync_q | cell_start;

  assign line_act   = line_counter >= 9'd12
                   && line_counter <= 9'd251;
  assign pix_act    = line_act
                   && clock_counter >= 11'd384
                   && clock_counter <= 11'd1919;
  assign frame_tick = clock_counter == 11'd0
                   && line_counter == 9'd0;

  assign line_off = line_counter - 9'd12;
  assign row_w    = {1'b0, line_off} >> 3;
  assign rd_idx   = row_w * 10'd32 + {4'd0, col_c};

  assign inv   = cursor_en && blink_q && idx_q == cursor_addr;
  assign wr_en = wr.wr_valid && ready_c
              && wr.wr_addr < 10'd960;
  assign load  = sync_c && phase_c == 6'd47 && col_c < 6'd32;

  assign wr.wr_ready = ready_c;
  assign dot         = dot_q;

  always_comb begin
    state_d   = state_q;
    ready_c   = 1'b1;
    font_addr = font_addr_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    unique case (state_q)
      IDLE: begin
        if (sync_c && phase_c == 6'd0
            && col_c < 6'd32 && line_act)
          state_d = CHAR;
      end
      CHAR: begin
        ready_c = 1'b0;
        idx_d   = rd_idx;
        state_d = FONT;
      end
      FONT: begin
        font_addr = {code_q, line_off[2:0]};
        state_d   = LATCH;
      end
      LATCH: begin
        pend_d  = font_data ^ {6{inv}};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    phase_d = (phase_c == 6'd47) ? 6'd0
                                 : phase_c + 6'd1;
    col_d   = col_c;
    if (phase_c == 6'd47 && col_c != 6'd32)
      col_d = col_c + 6'd1;

    shift_d = shift_q;
    if (load)
      shift_d = pend_q;
    else if (phase_c[2:0] == 3'd7)
      shift_d = {shift_q[4:0], 1'b0};

    frame_d = frame_q;
    blink_d = blink_q;
    if (frame_tick) begin
      frame_d = frame_q + 5'd1;
      if (frame_q == 5'd31)
        blink_d = ~blink_q;
    end

    dot_d = shift_q[5] & pix_act;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= 6'd0;
      col_q       <= 6'd0;
      sync_q      <= 1'b0;
      shift_q     <= 6'd0;
      pend_q      <= 6'd0;
      idx_q       <= 10'd0;
      font_addr_q <= 10'd0;
      frame_q     <= 5'd0;
      blink_q     <= 1'b0;
      dot_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      col_q       <= col_d;
      sync_q      <= sync_c;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      font_addr_q <= font_addr;
      frame_q     <= frame_d;
      blink_q     <= blink_d;
      dot_q       <= dot_d;
    end
  end

  // Single port: reads only in CHAR, when the host is held off.
  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wr.wr_addr] <= wr.wr_data;
    if (state_q == CHAR)
      code_q <= mem[rd_idx];
  end

endmodule
